multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-002 clk_i  input  1  clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 opcode_i  input  6  instruction[31:26] from instruction register.
REQ-005 mem_ready_i  input  1  memory handshake; access completes in cycle where high.
REQ-006 zero_i  input  1  ALU zero flag.
REQ-007 Outputs (1 bit): pc_write_o, pc_src_o, ir_write_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, error_o.
REQ-008 Outputs (multi-bit): alu_src_b_o 2 (0 RT, 1 const 4, 2 sign-ext imm, 3 imm<<2); alu_op_o 3 (0 add, 1 sub, 2 R-type funct, 3 slt); state_o 3 current state.
REQ-009 instr_cnt_o  output  CNT_W  retired-instruction count.

Function
REQ-010 States/encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7; outputs Moore-decoded from state and latched opcode; unlisted outputs 0.
REQ-011 IF: mem_read_o=1, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=0; ir_write_o and pc_write_o =1 only in cycle mem_ready_i=1; stay in IF while mem_ready_i=0; ->ID on ready.
REQ-012 ID: opcode_i latched into op_q; alu_src_b_o=3, alu_op_o=0 (branch target); legal opcodes 0 (R), 8 (addi), 10 (slti), 4 (beq), 35 (lw), 43 (sw) ->EX; others ->ERR.
REQ-013 EX: alu_src_a_o=1; R: alu_src_b_o=0, alu_op_o=2; addi/lw/sw: alu_src_b_o=2, alu_op_o=0; slti: alu_src_b_o=2, alu_op_o=3; beq: alu_src_b_o=0, alu_op_o=1, pc_src_o=1, pc_write_o=zero_i.
REQ-014 EX transitions: R/addi/slti ->WB; lw/sw ->MEM; beq ->IF.
REQ-015 MEM: lw mem_read_o=1, sw mem_write_o=1, held while mem_ready_i=0; on ready lw ->WB, sw ->IF.
REQ-016 WB: reg_write_o=1; reg_dst_o=1 for R only; mem_to_reg_o=1 for lw only; ->IF.
REQ-017 Zero-wait latencies: R/addi/slti/sw 4 cycles, beq 3, lw 5; each wait cycle with mem_ready_i=0 adds one.
REQ-018 ERR: all control outputs 0, error_o=1, sticky until reset.
REQ-019 Retirement event: WB exit, sw MEM exit with ready, beq EX exit.

Reset
REQ-020 rst_i=1 at a rising edge forces state IF, op_q=0, error_o=0, instr_cnt_o=0, regardless of current state (incl. mid-MEM wait).
REQ-021 Outputs during reset cycle follow state before edge; first post-reset cycle shows IF decode; no write strobe asserts in IF except pc_write_o/ir_write_o on ready.

Configuration
REQ-022 Macro MULTICYCLE_CTRL_RETIRE_CNT_EN: defined -> instr_cnt_o increments by 1 per retirement, wraps 2^CNT_W-1 to 0; undefined -> instr_cnt_o constant 0, no counter flops.

Verification
REQ-023 Reset, mem_ready_i=1, opcode 0 -> state_o 0,1,2,4,0; reg_write_o=1 and reg_dst_o=1 in cycle 4 only.
REQ-024 lw (35), mem_ready_i low 2 cycles in MEM -> MEM held 3 cycles, mem_read_o=1 throughout, WB mem_to_reg_o=1, 7 cycles total.
REQ-025 beq (4), zero_i=1 then zero_i=0 run -> EX pc_write_o=1, pc_src_o=1 first run; pc_write_o=0 second run; return IF after 3 cycles.
REQ-026 opcode 6'h3F at ID -> state_o=7, error_o=1 held 10 cycles; rst_i=1 one cycle -> state_o=0, error_o=0.
REQ-027 sw (43) with mem_ready_i=0, rst_i=1 in MEM -> next cycle state_o=0, mem_write_o=0.
REQ-028 With macro, CNT_W=4, 16 addi instructions -> instr_cnt_o reaches 15 then wraps to 0; without macro stays 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: datapath <-> multicycle controller control bundle
//   datapath->ctrl: opcode_i (IR[31:26]), mem_ready_i, zero_i
//   ctrl->datapath: write/select strobes, alu_src_b_o, alu_op_o, state_o, error_o, instr_cnt_o
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0] opcode_i;
  logic mem_ready_i, zero_i;
  logic pc_write_o, pc_src_o, ir_write_o, mem_read_o, mem_write_o;
  logic mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, error_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o, state_o;
  logic [CNT_W-1:0] instr_cnt_o;
  modport master(
    output opcode_i, mem_ready_i, zero_i,
    input pc_write_o, pc_src_o, ir_write_o, mem_read_o, mem_write_o, mem_to_reg_o,
    input reg_dst_o, reg_write_o, alu_src_a_o, error_o, alu_src_b_o, alu_op_o, state_o, instr_cnt_o
  );
  modport slave(
    input opcode_i, mem_ready_i, zero_i,
    output pc_write_o, pc_src_o, ir_write_o, mem_read_o, mem_write_o, mem_to_reg_o,
    output reg_dst_o, reg_write_o, alu_src_a_o, error_o, alu_src_b_o, alu_op_o, state_o, instr_cnt_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM controller for a multicycle MIPS-subset datapath
//   clk_i, rst_i (sync, active-high); bus: multicycle_ctrl_if.slave
//   Optional retired-instruction counter enabled by MULTICYCLE_CTRL_RETIRE_CNT_EN
module multicycle_ctrl #(parameter int CNT_W = 32) (
  input  logic clk_i,
  input  logic rst_i,
  multicycle_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_ERR = 3'd7
  } state_t;
  localparam logic [5:0] OP_R = 6'd0, OP_ADDI = 6'd8, OP_SLTI = 6'd10;
  localparam logic [5:0] OP_BEQ = 6'd4, OP_LW = 6'd35, OP_SW = 6'd43;
  state_t state, state_n;
  logic [5:0] op_q;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= S_IF;
      op_q  <= '0;
    end else begin
      state <= state_n;
      if (state == S_ID) op_q <= bus.opcode_i;
    end
  always_comb begin
    state_n          = state;
    bus.pc_write_o   = 1'b0;
    bus.pc_src_o     = 1'b0;
    bus.ir_write_o   = 1'b0;
    bus.mem_read_o   = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_to_reg_o = 1'b0;
    bus.reg_dst_o    = 1'b0;
    bus.reg_write_o  = 1'b0;
    bus.alu_src_a_o  = 1'b0;
    bus.error_o      = 1'b0;
    bus.alu_src_b_o  = 2'd0;
    bus.alu_op_o     = 3'd0;
    case (state)
      S_IF: begin
        bus.mem_read_o  = 1'b1;
        bus.alu_src_b_o = 2'd1;
        bus.ir_write_o  = bus.mem_ready_i;
        bus.pc_write_o  = bus.mem_ready_i;
        state_n = bus.mem_ready_i ? S_ID : S_IF;
      end
      S_ID: begin
        // opcode is decoded live here while op_q captures it for later states
        bus.alu_src_b_o = 2'd3;
        state_n = (bus.opcode_i inside {OP_R, OP_ADDI, OP_SLTI, OP_BEQ, OP_LW, OP_SW}) ? S_EX : S_ERR;
      end
      S_EX: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = (op_q == OP_R || op_q == OP_BEQ) ? 2'd0 : 2'd2;
        bus.alu_op_o = (op_q == OP_R) ? 3'd2 : (op_q == OP_SLTI) ? 3'd3 : (op_q == OP_BEQ) ? 3'd1 : 3'd0;
        bus.pc_src_o   = op_q == OP_BEQ;
        bus.pc_write_o = op_q == OP_BEQ && bus.zero_i;
        state_n = (op_q == OP_BEQ) ? S_IF : (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.mem_read_o  = op_q == OP_LW;
        bus.mem_write_o = op_q == OP_SW;
        state_n = !bus.mem_ready_i ? S_MEM : (op_q == OP_LW) ? S_WB : S_IF;
      end
      S_WB: begin
        bus.reg_write_o  = 1'b1;
        bus.reg_dst_o    = op_q == OP_R;
        bus.mem_to_reg_o = op_q == OP_LW;
        state_n = S_IF;
      end
      S_ERR: bus.error_o = 1'b1;
      default: state_n = S_ERR;
    endcase
  end
  assign bus.state_o = state;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic retire;
  assign retire = state == S_WB || (state == S_MEM && op_q == OP_SW && bus.mem_ready_i) || (state == S_EX && op_q == OP_BEQ);
  always_ff @(posedge clk_i)
    if (rst_i) cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  assign bus.instr_cnt_o = cnt_q;
`else
  assign bus.instr_cnt_o = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl (CNT_W=4)
module tb_multicycle_ctrl;
  typedef struct packed {
    logic [2:0] st;
    logic [9:0] f;
    logic [1:0] b;
    logic [2:0] op;
    logic [3:0] cnt;
  } exp_t;
  logic clk, rst;
  exp_t exp_q[$];
  string tag_q[$];
  int compared = 0, mismatched = 0;
  logic [3:0] exp_cnt = '0;
  multicycle_ctrl_if #(.CNT_W(4)) bus();
  multicycle_ctrl #(.CNT_W(4)) dut(.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      exp_t e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {bus.state_o, bus.pc_write_o, bus.pc_src_o, bus.ir_write_o, bus.mem_read_o, bus.mem_write_o,
           bus.mem_to_reg_o, bus.reg_dst_o, bus.reg_write_o, bus.alu_src_a_o, bus.error_o,
           bus.alu_src_b_o, bus.alu_op_o, bus.instr_cnt_o};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL %s: got st=%0d f=%b b=%0d op=%0d cnt=%0d, want st=%0d f=%b b=%0d op=%0d cnt=%0d",
                 t, a.st, a.f, a.b, a.op, a.cnt, e.st, e.f, e.b, e.op, e.cnt);
      end
    end
  task automatic cyc(input string tag, input logic rdy, input logic z, input logic [5:0] opc,
                     input logic [2:0] st, input logic [9:0] f, input logic [1:0] b, input logic [2:0] op,
                     input bit ret);
    bus.mem_ready_i = rdy;
    bus.zero_i = z;
    bus.opcode_i = opc;
    exp_q.push_back('{st: st, f: f, b: b, op: op, cnt: exp_cnt});
    tag_q.push_back(tag);
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    if (ret) exp_cnt = exp_cnt + 4'd1;
`endif
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input int w);
    repeat (w) cyc("if_wait", 1'b0, 1'b1, 6'h3F, 3'd0, 10'b0001000000, 2'd1, 3'd0, 0);
    cyc("if_rdy", 1'b1, 1'b1, 6'h3F, 3'd0, 10'b1011000000, 2'd1, 3'd0, 0);
  endtask
  task automatic decode(input logic [5:0] opc);
    cyc("id", 1'b1, 1'b1, opc, 3'd1, 10'b0, 2'd3, 3'd0, 0);
  endtask
  task automatic execute(input logic [5:0] opc, input logic z);
    case (opc)
      6'd0:  cyc("ex_r", 1'b1, 1'b1, 6'h3F, 3'd2, 10'b0000000010, 2'd0, 3'd2, 0);
      6'd10: cyc("ex_slti", 1'b1, 1'b1, 6'h3F, 3'd2, 10'b0000000010, 2'd2, 3'd3, 0);
      6'd4:  cyc("ex_beq", 1'b1, z, 6'h3F, 3'd2, {z, 1'b1, 6'b0, 1'b1, 1'b0}, 2'd0, 3'd1, 1);
      default: cyc("ex_imm", 1'b1, 1'b1, 6'h3F, 3'd2, 10'b0000000010, 2'd2, 3'd0, 0);
    endcase
  endtask
  task automatic run(input logic [5:0] opc, input int if_w, input int mem_w, input logic z);
    fetch(if_w);
    decode(opc);
    execute(opc, z);
    if (opc == 6'd35 || opc == 6'd43) begin
      logic [9:0] mf;
      mf = (opc == 6'd35) ? 10'b0001000000 : 10'b0000100000;
      repeat (mem_w) cyc("mem_wait", 1'b0, 1'b1, 6'h3F, 3'd3, mf, 2'd0, 3'd0, 0);
      cyc("mem_rdy", 1'b1, 1'b1, 6'h3F, 3'd3, mf, 2'd0, 3'd0, opc == 6'd43);
    end
    if (opc == 6'd0) cyc("wb_r", 1'b0, 1'b1, 6'h3F, 3'd4, 10'b0000001100, 2'd0, 3'd0, 1);
    else if (opc == 6'd35) cyc("wb_lw", 1'b0, 1'b1, 6'h3F, 3'd4, 10'b0000010100, 2'd0, 3'd0, 1);
    else if (opc == 6'd8 || opc == 6'd10) cyc("wb_imm", 1'b0, 1'b1, 6'h3F, 3'd4, 10'b0000000100, 2'd0, 3'd0, 1);
  endtask
  initial begin
    rst = 1'b1;
    bus.mem_ready_i = 1'b0;
    bus.zero_i = 1'b0;
    bus.opcode_i = 6'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run(6'd0, 0, 0, 1'b0);
    run(6'd8, 0, 0, 1'b0);
    run(6'd10, 0, 0, 1'b0);
    run(6'd35, 0, 2, 1'b0);
    run(6'd43, 1, 1, 1'b0);
    run(6'd4, 0, 0, 1'b1);
    run(6'd4, 0, 0, 1'b0);
    run(6'd35, 0, 0, 1'b0);
    fetch(0);
    decode(6'h3F);
    for (int i = 0; i < 10; i++)
      cyc("err_hold", i[0], 1'b1, 6'd0, 3'd7, 10'b0000000001, 2'd0, 3'd0, 0);
    rst = 1'b1;
    cyc("err_rst", 1'b1, 1'b1, 6'd0, 3'd7, 10'b0000000001, 2'd0, 3'd0, 0);
    rst = 1'b0;
    exp_cnt = '0;
    run(6'd0, 1, 0, 1'b0);
    fetch(0);
    decode(6'd43);
    execute(6'd43, 1'b0);
    rst = 1'b1;
    cyc("sw_rst", 1'b0, 1'b1, 6'h3F, 3'd3, 10'b0000100000, 2'd0, 3'd0, 0);
    rst = 1'b0;
    exp_cnt = '0;
    fetch(1);
    decode(6'd8);
    execute(6'd8, 1'b0);
    cyc("wb_imm", 1'b0, 1'b1, 6'h3F, 3'd4, 10'b0000000100, 2'd0, 3'd0, 1);
    for (int i = 0; i < 15; i++) run(6'd8, 0, 0, 1'b0);
    cyc("cnt_wrap", 1'b0, 1'b1, 6'h3F, 3'd0, 10'b0001000000, 2'd1, 3'd0, 0);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
